// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared encodings and field widths for the iterative RV32M unit
package ex_muldiv_pkg;

   localparam int ALUOP_W   = 7;
   localparam int F3_W      = 3;
   localparam int F7_W      = 7;
   localparam int REGADDR_W = 5;

   localparam logic [ALUOP_W-1:0] OP_REG        = 7'b0110011;
   localparam logic [F7_W-1:0]    MULDIV_FUNCT7 = 7'b0000001;

   typedef enum logic [F3_W-1:0] {
      MUL_F3    = 3'b000,
      MULH_F3   = 3'b001,
      MULHSU_F3 = 3'b010,
      MULHU_F3  = 3'b011,
      DIV_F3    = 3'b100,
      DIVU_F3   = 3'b101,
      REM_F3    = 3'b110,
      REMU_F3   = 3'b111
   } md_funct3_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 only for MUL/MULH/DIV/REM
   function automatic logic rs1_signed(input logic [F3_W-1:0] f3);
      return f3[2] ? ~f3[0] : (f3[1:0] != 2'b11);
   endfunction

   function automatic logic rs2_signed(input logic [F3_W-1:0] f3);
      return f3[2] ? ~f3[0] : ~f3[1];
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - ID/EX operand bundle in, result/stall bundle out
interface ex_muldiv_if #(parameter int XLEN = 32);
   import ex_muldiv_pkg::*;

   logic [ALUOP_W-1:0]   aluop_i;
   logic [F3_W-1:0]      alufunct3_i;
   logic [F7_W-1:0]      alufunct7_i;
   logic [XLEN-1:0]      reg1_i;
   logic [XLEN-1:0]      reg2_i;
   logic [REGADDR_W-1:0] wd_i;
   logic                 wreg_i;
   logic                 flush_i;
   logic                 stallreq_o;
   logic [XLEN-1:0]      result_o;
   logic                 result_valid_o;
   logic [REGADDR_W-1:0] wd_o;
   logic                 wreg_o;

   modport master (
      output aluop_i, alufunct3_i, alufunct7_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      input  stallreq_o, result_o, result_valid_o, wd_o, wreg_o
   );

   modport slave (
      input  aluop_i, alufunct3_i, alufunct7_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
      output stallreq_o, result_o, result_valid_o, wd_o, wreg_o
   );

endinterface

// File: rtl/ex_muldiv_sign_fix.sv
// rtl/ex_muldiv_sign_fix.sv - conditional two's-complement negation for operands and results
module muldiv_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? ((~val_i) + W'(1)) : val_i;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative shift-add multiplier / restoring divider with pipeline stall request
module ex_muldiv
   import ex_muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   ex_muldiv_if.slave  bus
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e            state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [XLEN-1:0]      a_q, a_d;
   logic [2*XLEN-1:0]    acc_q, acc_d;
   logic [F3_W-1:0]      funct3_q, funct3_d;
   logic                 neg_q, neg_d;
   logic                 rem_neg_q, rem_neg_d;
   logic [REGADDR_W-1:0] wd_q, wd_d;
   logic                 wreg_q, wreg_d;
   logic [XLEN-1:0]      result_q, result_d;
   logic                 valid_q, valid_d;
   logic [REGADDR_W-1:0] wd_out_q, wd_out_d;
   logic                 wreg_out_q, wreg_out_d;

   logic start;
   assign start = rst && (bus.aluop_i == OP_REG) && (bus.alufunct7_i == MULDIV_FUNCT7)
                  && (state_q == MD_IDLE) && !bus.flush_i;

   logic a_neg, b_neg;
   logic [XLEN-1:0] mag_a, mag_b;
   assign a_neg = rs1_signed(bus.alufunct3_i) & bus.reg1_i[XLEN-1];
   assign b_neg = rs2_signed(bus.alufunct3_i) & bus.reg2_i[XLEN-1];

   muldiv_sign_fix #(.W(XLEN)) u_fix_a (.val_i(bus.reg1_i), .neg_i(a_neg), .val_o(mag_a));
   muldiv_sign_fix #(.W(XLEN)) u_fix_b (.val_i(bus.reg2_i), .neg_i(b_neg), .val_o(mag_b));

   // Divide-by-zero and signed overflow resolve without iterating
   logic div_zero, div_ovf, fast, fast_rem;
   logic [XLEN-1:0] fast_res;
   assign div_zero = (bus.reg2_i == '0);
   assign div_ovf  = ~bus.alufunct3_i[0] && (bus.reg1_i == MIN_NEG) && (bus.reg2_i == '1);
   assign fast     = bus.alufunct3_i[2] && (div_zero || div_ovf);
   assign fast_rem = bus.alufunct3_i[1];
   assign fast_res = div_zero ? (fast_rem ? bus.reg1_i : '1) : (fast_rem ? '0 : MIN_NEG);

   // One iteration: hi half is the partial product / partial remainder, lo half the shifting operand
   logic [XLEN:0]     add_sum, shifted, diff;
   logic [2*XLEN-1:0] mul_step, div_step, acc_step;
   assign add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : '0)};
   assign mul_step = {add_sum, acc_q[XLEN-1:1]};
   assign shifted  = acc_q[2*XLEN-1:XLEN-1];
   assign diff     = shifted - {1'b0, a_q};
   assign div_step = diff[XLEN] ? {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0],    acc_q[XLEN-2:0], 1'b1};
   assign acc_step = funct3_q[2] ? div_step : mul_step;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, final_res;
   muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_i(acc_step), .neg_i(neg_q), .val_o(prod_fix));
   muldiv_sign_fix #(.W(XLEN)) u_fix_quot (.val_i(acc_step[XLEN-1:0]), .neg_i(neg_q), .val_o(quot_fix));
   muldiv_sign_fix #(.W(XLEN)) u_fix_rem (.val_i(acc_step[2*XLEN-1:XLEN]), .neg_i(rem_neg_q), .val_o(rem_fix));

   always_comb begin
      if (funct3_q[2])
         final_res = funct3_q[1] ? rem_fix : quot_fix;
      else
         final_res = (funct3_q == MUL_F3) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      acc_d      = acc_q;
      funct3_d   = funct3_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      wd_d       = wd_q;
      wreg_d     = wreg_q;
      result_d   = '0;
      valid_d    = 1'b0;
      wd_out_d   = '0;
      wreg_out_d = 1'b0;
      unique case (state_q)
         MD_IDLE: begin
            if (start) begin
               funct3_d  = bus.alufunct3_i;
               neg_d     = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               wd_d      = bus.wd_i;
               wreg_d    = bus.wreg_i;
               cnt_d     = '0;
               a_d       = bus.alufunct3_i[2] ? mag_b : mag_a;
               acc_d     = {{XLEN{1'b0}}, (bus.alufunct3_i[2] ? mag_a : mag_b)};
               if (fast) begin
                  state_d    = MD_DONE;
                  result_d   = fast_res;
                  valid_d    = 1'b1;
                  wd_out_d   = bus.wd_i;
                  wreg_out_d = bus.wreg_i;
               end else begin
                  state_d = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(XLEN-1)) begin
               state_d    = MD_DONE;
               cnt_d      = '0;
               result_d   = final_res;
               valid_d    = 1'b1;
               wd_out_d   = wd_q;
               wreg_out_d = wreg_q;
            end
         end
         default: state_d = MD_IDLE;
      endcase
      if (bus.flush_i) begin
         state_d    = MD_IDLE;
         cnt_d      = '0;
         result_d   = '0;
         valid_d    = 1'b0;
         wd_out_d   = '0;
         wreg_out_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= MD_IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         acc_q      <= '0;
         funct3_q   <= '0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         wd_q       <= '0;
         wreg_q     <= 1'b0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         wd_out_q   <= '0;
         wreg_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         acc_q      <= acc_d;
         funct3_q   <= funct3_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         wd_q       <= wd_d;
         wreg_q     <= wreg_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
         wd_out_q   <= wd_out_d;
         wreg_out_q <= wreg_out_d;
      end
   end

   // A flush in the result cycle squashes it as well
   assign bus.stallreq_o     = ((state_q == MD_IDLE && start) || state_q == MD_CALC) && !bus.flush_i;
   assign bus.result_valid_o = valid_q && !bus.flush_i;
   assign bus.result_o       = bus.result_valid_o ? result_q : '0;
   assign bus.wd_o           = bus.result_valid_o ? wd_out_q : '0;
   assign bus.wreg_o         = wreg_out_q && !bus.flush_i;

endmodule
